// File: rtl/tx_upmix.sv
// rtl/tx_upmix.sv - transmit quadrature upconverter: sample FIFO, zero-order hold, I/Q mixer, DAC word
//
// Accepts baseband I/Q samples into a 4-deep FIFO, releases one every INTERP
// clocks into a hold register, mixes the held sample as I*cos - Q*sin against
// the NCO words and drives an offset-binary 8-bit DAC word.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   enable       run (1) / mute (0); mute zeroes the held sample and the tick counter
//   clear_flags  synchronous clear of underrun (a same-cycle underrun wins)
//   in_valid     sample offered on i_in/q_in
//   in_ready     FIFO has room
//   i_in, q_in   signed 16-bit baseband sample
//   fsin, fcos   10-bit NCO words, only [9:2] used as signed 8-bit
//   dac_data     offset-binary DAC word
//   sample_tick  one-clock pulse after a FIFO entry is popped
//   underrun     sticky: a tick found the FIFO empty
module tx_upmix #(
    parameter int INTERP = 64,
    parameter int SHIFT  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               clear_flags,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] i_in,
    input  logic signed [15:0] q_in,
    input  logic        [9:0]  fsin,
    input  logic        [9:0]  fcos,
    output logic        [7:0]  dac_data,
    output logic               sample_tick,
    output logic               underrun
);
    localparam int CW = $clog2(INTERP);

    logic signed [15:0] mem_i [4];
    logic signed [15:0] mem_q [4];
    logic        [1:0]  wr_ptr;
    logic        [1:0]  rd_ptr;
    logic        [2:0]  count;
    logic        [2:0]  count_next;
    logic        [CW-1:0] cnt;

    logic tick;
    logic empty;
    logic push;
    logic pop;

    logic signed [7:0]  c8_r;
    logic signed [7:0]  s8_r;
    logic signed [15:0] held_i;
    logic signed [15:0] held_q;
    logic signed [23:0] p_i;
    logic signed [23:0] p_q;
    logic signed [24:0] sum_r;
    logic signed [24:0] shifted;
    logic        [7:0]  sat;

    // The two NCO LSBs are dropped on purpose: the mixer runs on 8-bit trig words.
    logic unused_nco_lsbs;
    assign unused_nco_lsbs = ^{fsin[1:0], fcos[1:0]};

    assign tick  = enable && (cnt == CW'(INTERP - 1));
    assign empty = (count == 3'd0);
    assign push  = in_valid && in_ready;
    // Pop looks at the occupancy before this cycle's push, so a push into an
    // empty FIFO is not visible to a tick in the same cycle.
    assign pop   = tick && !empty;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 3'd1;
        end else if (pop && !push) begin
            count_next = count - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_i[wr_ptr] <= i_in;
            mem_q[wr_ptr] <= q_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            count       <= 3'd0;
            in_ready    <= 1'b1;
            cnt         <= '0;
            sample_tick <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            count       <= count_next;
            in_ready    <= (count_next != 3'd4);
            sample_tick <= pop;
            if (!enable || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (tick && empty) begin
                underrun <= 1'b1;
            end else if (clear_flags) begin
                underrun <= 1'b0;
            end
        end
    end

    // Four-stage datapath: hold/NCO capture, products, difference, DAC word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c8_r     <= '0;
            s8_r     <= '0;
            held_i   <= '0;
            held_q   <= '0;
            p_i      <= '0;
            p_q      <= '0;
            sum_r    <= '0;
            dac_data <= 8'h80;
        end else begin
            c8_r <= fcos[9:2];
            s8_r <= fsin[9:2];
            if (!enable) begin
                held_i <= '0;
                held_q <= '0;
            end else if (tick) begin
                if (!empty) begin
                    held_i <= mem_i[rd_ptr];
                    held_q <= mem_q[rd_ptr];
                end else begin
                    held_i <= '0;
                    held_q <= '0;
                end
            end
            p_i      <= $signed({{8{held_i[15]}}, held_i}) * $signed({{16{c8_r[7]}}, c8_r});
            p_q      <= $signed({{8{held_q[15]}}, held_q}) * $signed({{16{s8_r[7]}}, s8_r});
            sum_r    <= $signed({p_i[23], p_i}) - $signed({p_q[23], p_q});
            // Offset binary: adding 128 to a two's complement byte flips its MSB.
            dac_data <= {~sat[7], sat[6:0]};
        end
    end

    always_comb begin
        shifted = sum_r >>> SHIFT;
        if (shifted > 25'sd127) begin
            sat = 8'h7F;
        end else if (shifted < -25'sd128) begin
            sat = 8'h80;
        end else begin
            sat = shifted[7:0];
        end
    end
endmodule

// File: tb/tb_tx_upmix.sv
// tb/tb_tx_upmix.sv - scoreboard bench for tx_upmix at SHIFT=16 and SHIFT=15
module tb_tx_upmix;
    localparam int INTERP = 4;

    logic clk = 1'b0;
    logic reset, enable, clear_flags, in_valid;
    logic signed [15:0] i_in, q_in;
    logic [9:0] fsin, fcos;
    logic rdy_a, rdy_b, stk_a, stk_b, und_a, und_b;
    logic [7:0] dac_a, dac_b;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    tx_upmix #(.INTERP(INTERP), .SHIFT(16)) dut_a (
        .clk(clk), .reset(reset), .enable(enable), .clear_flags(clear_flags),
        .in_valid(in_valid), .in_ready(rdy_a), .i_in(i_in), .q_in(q_in),
        .fsin(fsin), .fcos(fcos), .dac_data(dac_a), .sample_tick(stk_a), .underrun(und_a)
    );

    tx_upmix #(.INTERP(INTERP), .SHIFT(15)) dut_b (
        .clk(clk), .reset(reset), .enable(enable), .clear_flags(clear_flags),
        .in_valid(in_valid), .in_ready(rdy_b), .i_in(i_in), .q_in(q_in),
        .fsin(fsin), .fcos(fcos), .dac_data(dac_b), .sample_tick(stk_b), .underrun(und_b)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as queues, expected DAC words queued three edges ahead.
    int mq_i[$];
    int mq_q[$];
    int exp_a[$];
    int exp_b[$];
    int m_cnt, m_hi, m_hq, m_c8, m_s8;
    bit m_ready, m_stick, m_und, m_under, m_tick;
    longint m_sum;

    function automatic int to_dac(input longint sum, input int sh);
        longint d;
        longint v;
        d = longint'(1) << sh;
        v = sum / d;
        if ((sum % d) != 0 && sum < 0) v = v - 1;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return int'(v) + 128;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq_i.delete(); mq_q.delete(); exp_a.delete(); exp_b.delete();
            for (int k = 0; k < 3; k++) begin
                exp_a.push_back(128);
                exp_b.push_back(128);
            end
            m_cnt = 0; m_hi = 0; m_hq = 0;
            m_ready = 1; m_stick = 0; m_und = 0;
        end else begin
            m_tick  = enable && (m_cnt == INTERP - 1);
            m_under = 0;
            m_stick = 0;
            if (!enable) begin
                m_cnt = 0; m_hi = 0; m_hq = 0;
            end else if (m_tick) begin
                m_cnt = 0;
                if (mq_i.size() > 0) begin
                    m_hi = mq_i.pop_front();
                    m_hq = mq_q.pop_front();
                    m_stick = 1;
                end else begin
                    m_hi = 0; m_hq = 0; m_under = 1;
                end
            end else begin
                m_cnt = m_cnt + 1;
            end
            if (in_valid && m_ready) begin
                mq_i.push_back(int'(i_in));
                mq_q.push_back(int'(q_in));
            end
            m_ready = (mq_i.size() < 4);
            if (m_under) m_und = 1;
            else if (clear_flags) m_und = 0;
            m_c8 = int'($signed(fcos[9:2]));
            m_s8 = int'($signed(fsin[9:2]));
            m_sum = longint'(m_hi) * m_c8 - longint'(m_hq) * m_s8;
            exp_a.push_back(to_dac(m_sum, 16));
            exp_b.push_back(to_dac(m_sum, 15));
        end
    end

    always @(negedge clk) begin
        if (!reset && exp_a.size() >= 4) begin
            check("dac_shift16", int'(dac_a), exp_a.pop_front());
            check("dac_shift15", int'(dac_b), exp_b.pop_front());
            check("in_ready_a", int'(rdy_a), int'(m_ready));
            check("in_ready_b", int'(rdy_b), int'(m_ready));
            check("sample_tick_a", int'(stk_a), int'(m_stick));
            check("sample_tick_b", int'(stk_b), int'(m_stick));
            check("underrun_a", int'(und_a), int'(m_und));
            check("underrun_b", int'(und_b), int'(m_und));
        end
    end

    function automatic logic [15:0] pick16();
        case ($urandom_range(0, 7))
            0: return 16'h7FFF;
            1: return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic random_phase(input int ncyc, input int pv);
        for (int n = 0; n < ncyc; n++) begin
            in_valid    = ($urandom_range(0, 99) < pv);
            i_in        = pick16();
            q_in        = pick16();
            fsin        = 10'($urandom);
            fcos        = 10'($urandom);
            enable      = ($urandom_range(0, 31) != 0);
            clear_flags = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
    endtask

    // Empty the FIFO, clear the flag, leave the block muted with the counter at 0.
    task automatic drain();
        in_valid = 0; clear_flags = 0; enable = 1;
        repeat (5 * INTERP) @(negedge clk);
        clear_flags = 1;
        @(negedge clk);
        clear_flags = 0; enable = 0;
        @(negedge clk);
    endtask

    task automatic mix_case(input string nm, input int iv, input int qv,
                            input logic [9:0] fc, input logic [9:0] fs,
                            input int want_a, input int want_b);
        int k;
        drain();
        fcos = fc; fsin = fs;
        i_in = 16'(iv); q_in = 16'(qv); in_valid = 1;
        @(negedge clk);
        in_valid = 0; enable = 1;
        k = 0;
        while (stk_a !== 1'b1 && k < 3 * INTERP) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_tick"}, int'(stk_a), 1);
        repeat (3) @(negedge clk);
        for (int h = 0; h < INTERP; h++) begin
            check({nm, "_shift16"}, int'(dac_a), want_a);
            check({nm, "_shift15"}, int'(dac_b), want_b);
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: summary not reached");
        $fatal(1, "timeout");
    end

    initial begin
        int nacc;
        int c;
        bit was;
        reset = 0; enable = 0; clear_flags = 0; in_valid = 0;
        i_in = 0; q_in = 0; fsin = 0; fcos = 0;
        #1 reset = 1;
        #1;
        check("por_dac", int'(dac_a), 128);
        check("por_in_ready", int'(rdy_a), 1);
        check("por_sample_tick", int'(stk_a), 0);
        check("por_underrun", int'(und_a), 0);
        repeat (2) @(negedge clk);
        reset = 0;

        random_phase(1200, 20);
        random_phase(1200, 45);
        random_phase(600, 90);

        // Asynchronous reset in the middle of traffic.
        #2 reset = 1;
        #1;
        check("rst_dac_a", int'(dac_a), 128);
        check("rst_dac_b", int'(dac_b), 128);
        check("rst_in_ready", int'(rdy_a), 1);
        check("rst_sample_tick", int'(stk_a), 0);
        check("rst_underrun", int'(und_a), 0);
        @(negedge clk);
        reset = 0;
        random_phase(400, 60);

        mix_case("dc_i",  16384, 0, 10'h1FC, 10'h000, 8'h9F, 8'hBF);
        mix_case("q_path", 0, 16384, 10'h000, 10'h1FC, 8'h60, 8'h40);
        mix_case("sat_hi", 32767, -32768, 10'h1FC, 10'h1FC, 8'hFE, 8'hFF);
        mix_case("sat_lo", -32768, 32767, 10'h1FC, 10'h1FC, 8'h01, 8'h00);

        // Backpressure: muted, five samples offered back to back.
        drain();
        fcos = 10'h1FC; fsin = 10'h0A8;
        nacc = 0;
        for (int n = 0; n < 7; n++) begin
            in_valid = 1;
            i_in = 16'(3000 * (nacc + 1));
            q_in = 16'(-2000 * (nacc + 1));
            was = rdy_a;
            @(negedge clk);
            if (was) nacc++;
        end
        check("bp_accepted", nacc, 4);
        check("bp_ready_low", int'(rdy_a), 0);
        enable = 1;
        c = 0;
        while (rdy_a !== 1'b1 && c < 3 * INTERP) begin
            @(negedge clk);
            c++;
        end
        check("bp_ready_back", int'(rdy_a), 1);
        check("bp_pop_with_ready", int'(stk_a), 1);
        @(negedge clk);
        check("bp_fifth_taken", int'(rdy_a), 0);
        in_valid = 0;
        c = 1;
        while (stk_a !== 1'b1 && c < 3 * INTERP) begin
            @(negedge clk);
            c++;
        end
        check("bp_pop_spacing", c, INTERP);

        // Underrun: one sample, then an empty tick.
        drain();
        fcos = 10'h1FC; fsin = 10'h000;
        i_in = 16'sd8192; q_in = 16'sd0; in_valid = 1;
        @(negedge clk);
        in_valid = 0; enable = 1;
        c = 0;
        while (stk_a !== 1'b1 && c < 3 * INTERP) begin
            @(negedge clk);
            c++;
        end
        check("ur_first_pop", int'(stk_a), 1);
        check("ur_not_yet", int'(und_a), 0);
        c = 0;
        while (und_a !== 1'b1 && c < 3 * INTERP) begin
            @(negedge clk);
            c++;
        end
        check("ur_spacing", c, INTERP);
        check("ur_flag", int'(und_a), 1);
        check("ur_no_tick", int'(stk_a), 0);
        repeat (3) @(negedge clk);
        check("ur_dac_mid", int'(dac_a), 128);
        enable = 0; clear_flags = 1;
        @(negedge clk);
        check("ur_cleared", int'(und_a), 0);
        enable = 1;
        repeat (INTERP) @(negedge clk);
        check("ur_set_wins", int'(und_a), 1);
        @(negedge clk);
        check("ur_clear_after", int'(und_a), 0);
        clear_flags = 0;

        random_phase(300, 30);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/tx_upmix.md
# tx_upmix

Transmit-side quadrature upconverter: accepts baseband I/Q samples over a valid/ready handshake and buffers them in a 4-entry FIFO. It releases one sample every INTERP clocks with zero-order hold, mixes the held sample with the NCO sin/cos words as I·cos − Q·sin, and drives an 8-bit offset-binary DAC word. It sits between the baseband sample source and the DAC pins. It is the transmit counterpart of the receive mixer that converts ADC data into I/Q products.

## Interface
Parameters:
- INTERP, 64: clocks per baseband sample (≥2).
- SHIFT, 16: arithmetic right shift applied to the 25-bit mixer sum before saturation.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run/mute control.
- clear_flags  in  1  synchronous clear of `underrun`.
- in_valid  in  1  sample offered.
- in_ready  out  1  FIFO not full.
- i_in  in  16  signed I sample.
- q_in  in  16  signed Q sample.
- fsin  in  10  NCO sine, two's complement; only [9:2] used, as signed 8-bit.
- fcos  in  10  NCO cosine, same format as fsin.
- dac_data  out  8  offset-binary DAC word.
- sample_tick  out  1  one-clock pulse when a FIFO entry is popped.
- underrun  out  1  sticky flag: a tick found the FIFO empty.

## Operation
- Reset values: dac_data=8'h80, in_ready=1, sample_tick=0, underrun=0. FIFO empty, tick counter 0, held I/Q 0, all pipeline registers 0.
- FIFO: 4 entries; push when in_valid && in_ready; in_ready = !full (registered from occupancy).
- Push and pop in the same cycle are both honoured. Occupancy is unchanged.
- A push into an empty FIFO is not visible to a pop in the same cycle. That cycle counts as empty.
- Tick counter: runs 0..INTERP−1 while enable=1. tick = enable && (cnt==INTERP−1); the counter wraps to 0 on tick.
- On tick with FIFO non-empty: pop the entry into held_i/held_q; sample_tick=1 the next cycle.
- On tick with FIFO empty: held_i/held_q←0 and underrun←1 (sticky). sample_tick stays 0.
- clear_flags=1 clears underrun. If an underrun occurs in the same cycle, set wins.
- enable=0: counter forced to 0, held_i/held_q forced to 0, no pops. FIFO contents and pushes are unaffected.
- Arithmetic: c8=fcos[9:2] and s8=fsin[9:2] (signed). p_i=held_i·c8 and p_q=held_q·s8 (24-bit signed). sum=p_i−p_q (25-bit signed, no overflow).
- Scaling: v = sum >>> SHIFT (arithmetic, floor). Saturate v to [−128,127]. dac_data = sat + 128 (MSB inverted).

## Timing
- Pipeline stage A (edge t): c8/s8 registered; held_i/held_q loaded if tick.
- Stage B (t+1): p_i and p_q registered.
- Stage C (t+2): sum registered.
- Stage D (t+3): dac_data registered.
- NCO word sampled at edge t appears on dac_data after edge t+3 (latency 4 clocks).
- A sample popped at edge t first affects dac_data after edge t+3. It holds for exactly INTERP clocks.
- Throughput: one DAC word per clock. One FIFO pop per INTERP clocks.
- in_ready updates the cycle after the occupancy change. After the 4th accepted push, in_ready=0 until a pop.
- Reset asserted mid-operation immediately returns all state to reset values, asynchronously. Partially accepted data is discarded.

## Test plan
- Reset: assert reset mid-stream → dac_data=8'h80, in_ready=1, underrun=0, sample_tick=0 with no clock edge needed.
- DC I: INTERP=4, SHIFT=16; push I=16384, Q=0; fcos=10'h1FC, fsin=0; enable=1 → after tick plus 4 clocks dac_data=8'h9F (v=31), held for 4 clocks.
- Q path: I=0, Q=16384, fsin=10'h1FC, fcos=0 → dac_data=8'h60 (v=−32, floor).
- Saturation: SHIFT=15; fcos=fsin=10'h1FC.
  - I=32767, Q=−32768 → v=253 → dac_data=8'hFF.
  - I=−32768, Q=32767 → v=−254 → dac_data=8'h00.
- Backpressure: enable=0; offer 5 samples back-to-back → 4 accepted; in_ready=0 after the 4th; 5th held. Then enable=1 → pops at ticks spaced INTERP clocks, and the 5th is accepted the cycle after in_ready returns to 1.
- Underrun: INTERP=4; push one sample, enable → first tick pops it (sample_tick=1). Second tick → underrun=1, dac_data returns to 8'h80 four clocks later. Pulse clear_flags → underrun=0.
